dcache_miss_controller: RTL and testbench

//  Sequences LW/SW data accesses of the single-cycle MIPS core through a direct-mapped, write-back data cache.

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_tag_store.sv | 55 +++++
 rtl/dcache_miss_controller.sv | 181 ++++++++++++++++++
 tb/tb_dcache_miss_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, default widths and address-field helpers for the data-cache miss controller.
package dcache_pkg;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_INDEX_W  = 6;
   localparam int DEF_OFFSET_W = 2;
   localparam int FIELD_W      = 64;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } state_t;

   // Helpers work on a zero-extended address so any ADDR_W up to FIELD_W is supported;
   // callers size-cast the result to the field width they need.
   function automatic logic [FIELD_W-1:0] get_tag(input logic [FIELD_W-1:0] addr,
                                                  input int index_w, input int offset_w);
      return addr >> (index_w + offset_w + 2);
   endfunction

   function automatic logic [FIELD_W-1:0] get_index(input logic [FIELD_W-1:0] addr,
                                                    input int index_w, input int offset_w);
      return (addr >> (offset_w + 2)) & ((FIELD_W'(1) << index_w) - FIELD_W'(1));
   endfunction

   function automatic logic [FIELD_W-1:0] get_offset(input logic [FIELD_W-1:0] addr,
                                                     input int offset_w);
      return (addr >> 2) & ((FIELD_W'(1) << offset_w) - FIELD_W'(1));
   endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Tag/valid/dirty arrays of the direct-mapped cache: async read port, sync writes.
// Latency: read is combinational, writes land on the next posedge.
// Backpressure: none; clear has priority over fill and dirty updates.
module dcache_tag_store
   import dcache_pkg::*;
#(
   parameter int INDEX_W = DEF_INDEX_W,
   parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W - 2
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic               rd_dirty,
   output logic [TAG_W-1:0]   rd_tag,
   input  logic               fill_en,
   input  logic [INDEX_W-1:0] fill_index,
   input  logic [TAG_W-1:0]   fill_tag,
   input  logic               dirty_en,
   input  logic [INDEX_W-1:0] dirty_index
);

   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_q [LINES];

   assign rd_valid = valid_q[rd_index];
   assign rd_dirty = dirty_q[rd_index];
   assign rd_tag   = tag_q[rd_index];

   always_ff @(posedge clk) begin
      if (clr) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (fill_en) begin
            valid_q[fill_index] <= 1'b1;
            dirty_q[fill_index] <= 1'b0;
         end
         if (dirty_en) begin
            dirty_q[dirty_index] <= 1'b1;
         end
      end
   end

   // Tags are deliberately not cleared: a cleared valid bit already hides them.
   always_ff @(posedge clk) begin
      if (fill_en && !clr) begin
         tag_q[fill_index] <= fill_tag;
      end
   end

endmodule

// File: rtl/dcache_miss_controller.sv
// Miss sequencer for the write-back direct-mapped D-cache: hit lookup, victim write-back, line refill.
// Latency: hits complete in the request cycle; a miss costs the beats plus memory wait plus one cycle.
// Backpressure: hit=0 stalls the core; each memory beat is held until mem_ready.
module dcache_miss_controller
   import dcache_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int INDEX_W  = DEF_INDEX_W,
   parameter int OFFSET_W = DEF_OFFSET_W
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   output logic                hit,
   output logic                cache_we,
   output logic [INDEX_W-1:0]  cache_index,
   output logic [OFFSET_W-1:0] cache_word,
   output logic                fill_sel,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_ready
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
   localparam logic [OFFSET_W-1:0] LAST_BEAT = {OFFSET_W{1'b1}};

   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]    t,
                                                   input logic [INDEX_W-1:0]  i,
                                                   input logic [OFFSET_W-1:0] b);
      return {t, i, b, 2'b00};
   endfunction

   state_t              state;
   logic [OFFSET_W-1:0] beat;
   logic [TAG_W-1:0]    req_tag;
   logic [TAG_W-1:0]    victim_tag;
   logic [INDEX_W-1:0]  req_index;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;

   logic [TAG_W-1:0]    lookup_tag;
   logic [INDEX_W-1:0]  lookup_index;
   logic [OFFSET_W-1:0] lookup_offset;
   logic                rd_valid;
   logic                rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   logic                lookup_hit;
   logic [OFFSET_W-1:0] beat_nxt;
   logic                last_beat;
   logic                fill_en;
   logic                dirty_en;

   assign lookup_tag    = TAG_W'(get_tag(FIELD_W'(cpu_addr), INDEX_W, OFFSET_W));
   assign lookup_index  = INDEX_W'(get_index(FIELD_W'(cpu_addr), INDEX_W, OFFSET_W));
   assign lookup_offset = OFFSET_W'(get_offset(FIELD_W'(cpu_addr), OFFSET_W));
   assign lookup_hit    = rd_valid && (rd_tag == lookup_tag);
   assign beat_nxt      = beat + 1'b1;
   assign last_beat     = (beat == LAST_BEAT);

   assign fill_en  = rst_b && (state == REFILL) && mem_ready && last_beat;
   assign dirty_en = hit && cpu_we;

   dcache_tag_store #(
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W)
   ) u_tag_store (
      .clk         (clk),
      .clr         (!rst_b),
      .rd_index    (lookup_index),
      .rd_valid    (rd_valid),
      .rd_dirty    (rd_dirty),
      .rd_tag      (rd_tag),
      .fill_en     (fill_en),
      .fill_index  (req_index),
      .fill_tag    (req_tag),
      .dirty_en    (dirty_en),
      .dirty_index (lookup_index)
   );

   // Memory-side outputs are registered alongside the state so they carry no cpu_* paths.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state      <= IDLE;
         beat       <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_req && !lookup_hit) begin
                  req_tag    <= lookup_tag;
                  req_index  <= lookup_index;
                  victim_tag <= rd_tag;
                  beat       <= '0;
                  mem_req_q  <= 1'b1;
                  if (rd_valid && rd_dirty) begin
                     state      <= WRITEBACK;
                     mem_we_q   <= 1'b1;
                     mem_addr_q <= line_addr(rd_tag, lookup_index, '0);
                  end else begin
                     state      <= REFILL;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= line_addr(lookup_tag, lookup_index, '0);
                  end
               end
            end
            WRITEBACK: begin
               if (mem_ready) begin
                  if (last_beat) begin
                     beat       <= '0;
                     state      <= REFILL;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= line_addr(req_tag, req_index, '0);
                  end else begin
                     beat       <= beat_nxt;
                     mem_addr_q <= line_addr(victim_tag, req_index, beat_nxt);
                  end
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  if (last_beat) begin
                     beat       <= '0;
                     state      <= IDLE;
                     mem_req_q  <= 1'b0;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= '0;
                  end else begin
                     beat       <= beat_nxt;
                     mem_addr_q <= line_addr(req_tag, req_index, beat_nxt);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign mem_req  = rst_b && mem_req_q;
   assign mem_we   = rst_b && mem_we_q;
   assign mem_addr = rst_b ? mem_addr_q : '0;

   always_comb begin
      hit         = 1'b0;
      cache_we    = 1'b0;
      cache_index = '0;
      cache_word  = '0;
      fill_sel    = 1'b0;
      if (rst_b) begin
         case (state)
            IDLE: begin
               if (cpu_req) begin
                  cache_index = lookup_index;
                  cache_word  = lookup_offset;
                  hit         = lookup_hit;
                  cache_we    = lookup_hit && cpu_we;
               end
            end
            WRITEBACK: begin
               cache_index = req_index;
               cache_word  = beat;
            end
            REFILL: begin
               cache_index = req_index;
               cache_word  = beat;
               cache_we    = mem_ready;
               fill_sel    = mem_ready;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_miss_controller.sv
module tb_dcache_miss_controller;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic        hit;
   logic        cache_we;
   logic [5:0]  cache_index;
   logic [1:0]  cache_word;
   logic        fill_sel;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic        mem_ready;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dcache_miss_controller dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .hit         (hit),
      .cache_we    (cache_we),
      .cache_index (cache_index),
      .cache_word  (cache_word),
      .fill_sel    (fill_sel),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready)
   );

   typedef struct packed {
      logic        hit;
      logic        cache_we;
      logic [5:0]  cache_index;
      logic [1:0]  cache_word;
      logic        fill_sel;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
   } outs_t;

   typedef struct {
      logic        rst_b;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic        rdy;
      outs_t       exp;
   } vec_t;

   vec_t vecs[$];

   task automatic row(input logic r, input logic q, input logic w, input logic [31:0] a,
                      input logic rdy, input logic h, input logic cwe, input logic [5:0] idx,
                      input logic [1:0] wd, input logic fs, input logic mrq, input logic mwe,
                      input logic [31:0] ma);
      vec_t v;
      v.rst_b = r; v.req = q; v.we = w; v.addr = a; v.rdy = rdy;
      v.exp = '{hit: h, cache_we: cwe, cache_index: idx, cache_word: wd, fill_sel: fs,
                mem_req: mrq, mem_we: mwe, mem_addr: ma};
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic q, input logic w, input logic [31:0] a,
                        input logic rdy);
      rst_b = r; cpu_req = q; cpu_we = w; cpu_addr = a; mem_ready = rdy;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   function automatic outs_t actual();
      return '{hit: hit, cache_we: cache_we, cache_index: cache_index, cache_word: cache_word,
               fill_sel: fill_sel, mem_req: mem_req, mem_we: mem_we, mem_addr: mem_addr};
   endfunction

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      // rst r  q  w  addr          rdy hit cwe idx wd fs mrq mwe mem_addr
      row(0, 1, 0, 32'h0000_0040, 0, 0, 0, 6'd0, 2'd0, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_0040, 0, 0, 0, 6'd4, 2'd0, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_0040, 0, 0, 0, 6'd4, 2'd0, 0, 1, 0, 32'h40);
      row(1, 1, 0, 32'h0000_0040, 1, 0, 1, 6'd4, 2'd0, 1, 1, 0, 32'h40);
      row(1, 1, 0, 32'h0000_0040, 1, 0, 1, 6'd4, 2'd1, 1, 1, 0, 32'h44);
      row(1, 1, 0, 32'h0000_0040, 1, 0, 1, 6'd4, 2'd2, 1, 1, 0, 32'h48);
      row(1, 1, 0, 32'h0000_0040, 1, 0, 1, 6'd4, 2'd3, 1, 1, 0, 32'h4C);
      row(1, 1, 0, 32'h0000_0040, 0, 1, 0, 6'd4, 2'd0, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_0044, 0, 1, 0, 6'd4, 2'd1, 0, 0, 0, 32'h0);
      row(1, 0, 0, 32'h0000_0044, 0, 0, 0, 6'd0, 2'd0, 0, 0, 0, 32'h0);
      row(1, 1, 1, 32'h0000_0048, 0, 1, 1, 6'd4, 2'd2, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_1040, 0, 0, 0, 6'd4, 2'd0, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_1040, 0, 0, 0, 6'd4, 2'd0, 0, 1, 1, 32'h40);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 0, 6'd4, 2'd0, 0, 1, 1, 32'h40);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 0, 6'd4, 2'd1, 0, 1, 1, 32'h44);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 0, 6'd4, 2'd2, 0, 1, 1, 32'h48);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 0, 6'd4, 2'd3, 0, 1, 1, 32'h4C);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 1, 6'd4, 2'd0, 1, 1, 0, 32'h1040);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 1, 6'd4, 2'd1, 1, 1, 0, 32'h1044);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 1, 6'd4, 2'd2, 1, 1, 0, 32'h1048);
      row(1, 1, 0, 32'h0000_1040, 1, 0, 1, 6'd4, 2'd3, 1, 1, 0, 32'h104C);
      row(1, 1, 0, 32'h0000_1040, 0, 1, 0, 6'd4, 2'd0, 0, 0, 0, 32'h0);
      row(1, 0, 0, 32'h0000_1040, 1, 0, 0, 6'd0, 2'd0, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_104C, 0, 1, 0, 6'd4, 2'd3, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_0040, 0, 0, 0, 6'd4, 2'd0, 0, 0, 0, 32'h0);
      row(1, 1, 0, 32'h0000_0040, 0, 0, 0, 6'd4, 2'd0, 0, 1, 0, 32'h40);

      adv();
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_b, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].rdy);
         @(negedge clk);
         chk($sformatf("vec%0d", i), 64'(actual()), 64'(vecs[i].exp));
         adv();
      end

      // Slow memory: each refill beat waits 5 cycles; request and address must hold.
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h40, 1'b0);
            @(negedge clk);
            chk($sformatf("slow_req_b%0d", b), 64'(mem_req), 64'(1'b1));
            chk($sformatf("slow_addr_b%0d", b), 64'(mem_addr), 64'(32'h40 + 32'(4 * b)));
            chk($sformatf("slow_hit_b%0d", b), 64'(hit), 64'(1'b0));
            adv();
         end
         drive(1'b1, 1'b1, 1'b0, 32'h40, 1'b1);
         @(negedge clk);
         chk($sformatf("slow_we_b%0d", b), 64'({cache_we, fill_sel, cache_word}),
             64'({1'b1, 1'b1, 2'(b)}));
         adv();
      end
      drive(1'b1, 1'b1, 1'b0, 32'h40, 1'b0);
      @(negedge clk);
      chk("slow_rehit", 64'(hit), 64'(1'b1));
      adv();

      // Reset during REFILL beat 2 abandons the transfer and invalidates the line.
      drive(1'b1, 1'b1, 1'b0, 32'h1040, 1'b0);
      @(negedge clk);
      chk("rst_miss", 64'(hit), 64'(1'b0));
      adv();
      for (int b = 0; b < 2; b++) begin
         drive(1'b1, 1'b1, 1'b0, 32'h1040, 1'b1);
         @(negedge clk);
         chk($sformatf("rst_beat%0d", b), 64'(mem_addr), 64'(32'h1040 + 32'(4 * b)));
         adv();
      end
      drive(1'b1, 1'b1, 1'b0, 32'h1040, 1'b0);
      @(negedge clk);
      chk("rst_beat2_addr", 64'(mem_addr), 64'(32'h1048));
      drive(1'b0, 1'b1, 1'b0, 32'h1040, 1'b0);
      @(negedge clk);
      chk("rst_low_outs", 64'({mem_req, hit, cache_we}), 64'(3'b000));
      adv();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("rst_after_req", 64'({mem_req, mem_addr}), 64'({1'b0, 32'h0}));
      adv();
      drive(1'b1, 1'b1, 1'b0, 32'h40, 1'b0);
      @(negedge clk);
      chk("rst_relw_miss", 64'(hit), 64'(1'b0));
      adv();
      @(negedge clk);
      chk("rst_refill_start", 64'({mem_req, mem_we, mem_addr}), 64'({1'b1, 1'b0, 32'h40}));
      adv();

      // Core drops the request mid-miss: the line still fills completely.
      for (int b = 0; b < 4; b++) begin
         drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
         @(negedge clk);
         chk($sformatf("drop_beat%0d", b), 64'({cache_we, fill_sel, cache_word, mem_addr}),
             64'({1'b1, 1'b1, 2'(b), 32'h40 + 32'(4 * b)}));
         adv();
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      chk("drop_idle", 64'({hit, mem_req}), 64'(2'b00));
      adv();
      drive(1'b1, 1'b1, 1'b0, 32'h48, 1'b0);
      @(negedge clk);
      chk("drop_line_hit", 64'({hit, cache_word}), 64'({1'b1, 2'd2}));
      adv();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
